conv_mac_sequencer: RTL and testbench

CONV_MAC_SEQUENCER -- requirements
Module: conv_mac_sequencer

---
 rtl/conv_pkg.sv | 7 +
 rtl/conv_mac_sequencer.sv | 109 ++++++++++
 tb/tb_conv_mac_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution MAC sequencer.
package conv_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int KERNEL_LEN = 25;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, OUT} state_t;
endpackage

// File: rtl/conv_mac_sequencer.sv
// Sequences operand beats into an external accumulating PE, one window of
// KERNEL_LEN beats at a time, and hands each window result to the output stream.
module conv_mac_sequencer #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int KERNEL_LEN = conv_pkg::KERNEL_LEN,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_windows,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  pe_clear,
    output logic [DATA_WIDTH-1:0] pe_floatA,
    output logic [DATA_WIDTH-1:0] pe_floatB,
    input  logic [DATA_WIDTH-1:0] pe_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);
    import conv_pkg::*;

    localparam int BEAT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

    state_t                state, nextState;
    logic [BEAT_W-1:0]     beatCnt;
    logic [CNT_WIDTH-1:0]  winLeft;
    logic [DATA_WIDTH-1:0] outData;
    logic                  doneZero;
    logic                  beat;

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        pe_clear  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        beat      = 1'b0;
        if (reset) begin
            // Reset also clears the PE so a mid-job abort leaves no residue.
            pe_clear  = 1'b1;
            nextState = IDLE;
        end else begin
            busy = (state != IDLE);
            done = doneZero;
            unique case (state)
                IDLE: begin
                    if (start && num_windows != '0) nextState = CLEAR;
                end
                CLEAR: begin
                    pe_clear  = 1'b1;
                    nextState = ACCUM;
                end
                ACCUM: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        beat = 1'b1;
                        if (beatCnt == BEAT_W'(KERNEL_LEN - 1)) nextState = DRAIN;
                    end
                end
                DRAIN: nextState = OUT;
                OUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        if (winLeft == CNT_WIDTH'(1)) begin
                            done      = 1'b1;
                            nextState = IDLE;
                        end else begin
                            nextState = CLEAR;
                        end
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // Zero operands on idle cycles make the PE add 0*0, holding its sum.
    assign pe_floatA = beat ? in_a : '0;
    assign pe_floatB = beat ? in_b : '0;
    assign out_data  = reset ? '0 : outData;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beatCnt  <= '0;
            winLeft  <= '0;
            outData  <= '0;
            doneZero <= 1'b0;
        end else begin
            state    <= nextState;
            doneZero <= (state == IDLE) && start && (num_windows == '0);
            case (state)
                IDLE:  if (start && num_windows != '0) winLeft <= num_windows;
                CLEAR: beatCnt <= '0;
                ACCUM: if (beat) beatCnt <= beatCnt + 1'b1;
                DRAIN: outData <= pe_result;
                OUT:   if (out_ready) winLeft <= winLeft - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with a behavioural accumulating PE.
module tb_conv_mac_sequencer;
    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] TWO   = 32'h40000000;
    localparam logic [31:0] THREE = 32'h40400000;
    localparam logic [31:0] HALF  = 32'h3F000000;
    localparam logic [31:0] FOUR  = 32'h40800000;
    localparam logic [31:0] R50   = 32'h42480000;
    localparam logic [31:0] R150  = 32'h43160000;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] num_windows = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, pe_clear, out_valid, busy, done;
    logic [31:0] pe_floatA, pe_floatB, pe_result, out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_mac_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .num_windows(num_windows),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .pe_clear(pe_clear), .pe_floatA(pe_floatA), .pe_floatB(pe_floatB),
        .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  m;
        int   e;
        logic s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    // Accumulating PE: pe_clear acts as its reset.
    real acc = 0.0;
    always @(posedge clk) begin
        if (pe_clear) acc <= 0.0;
        else          acc <= acc + f2r(pe_floatA) * f2r(pe_floatB);
    end
    always_comb pe_result = r2f(acc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] a0, b0, a1, b1;
        int          gap, hold, restart;
        logic [31:0] expRes;
        int          expFirst, expDone;
    } vec_t;

    vec_t vecs[6];

    // Caller is positioned just after a rising edge; cycle 0 is the start cycle.
    task automatic runJob(input vec_t v);
        int win = 0, beats = 0, outs = 0, holdCnt = 0, zeroViol = 0, holdViol = 0;
        int firstOut = -1, doneCyc = -1, doneCnt = 0;
        logic [31:0] heldData = '0;
        real heldAcc = 0.0;
        start = 1'b1; num_windows = 16'(v.n); in_valid = 1'b1;
        out_ready = (v.hold == 0); in_a = v.a0; in_b = v.b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (in_valid && in_ready) beats++;
            else if (pe_floatA != 32'h0 || pe_floatB != 32'h0) zeroViol++;
            if (out_valid) begin
                if (firstOut < 0) firstOut = cyc;
                if (!out_ready) begin
                    if (holdCnt == 0) begin heldData = out_data; heldAcc = acc; end
                    else if (out_data !== heldData || acc != heldAcc) holdViol++;
                    if (in_ready) holdViol++;
                    holdCnt++;
                end else begin
                    check({v.name, " result"}, out_data, v.expRes);
                    outs++;
                    win++;
                end
            end
            if (done) begin doneCyc = cyc; doneCnt++; end
            tick();
            if (doneCyc >= 0 && cyc >= doneCyc + 3) break;
            start       = (cyc + 1 == v.restart);
            num_windows = (cyc + 1 == v.restart) ? 16'd5 : 16'(v.n);
            in_valid    = (v.gap != 0) ? ((cyc + 1) % 2 == 0) : 1'b1;
            out_ready   = (holdCnt >= v.hold);
            in_a        = (win == 1) ? v.a1 : v.a0;
            in_b        = (win == 1) ? v.b1 : v.b0;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check({v.name, " first out cycle"}, 32'(firstOut), 32'(v.expFirst));
        check({v.name, " done cycle"}, 32'(doneCyc), 32'(v.expDone));
        check({v.name, " done count"}, 32'(doneCnt), 32'd1);
        check({v.name, " outputs"}, 32'(outs), 32'(v.n));
        check({v.name, " beats"}, 32'(beats), 32'(25 * v.n));
        check({v.name, " zero operands"}, 32'(zeroViol), 32'd0);
        check({v.name, " hold stable"}, 32'(holdViol), 32'd0);
        check({v.name, " idle after"}, {30'd0, busy, out_valid}, 32'd0);
    endtask

    initial begin
        int beats;
        logic sawIo;

        vecs[0] = '{"cont",    1, ONE, TWO, ONE,  TWO,   0, 0,  0,  R50,  28, 28};
        vecs[1] = '{"gap",     1, ONE, TWO, ONE,  TWO,   1, 0,  0,  R50,  52, 52};
        vecs[2] = '{"multi",   3, ONE, TWO, HALF, FOUR,  0, 0,  0,  R50,  28, 84};
        vecs[3] = '{"hold",    1, ONE, TWO, ONE,  TWO,   0, 10, 0,  R50,  28, 38};
        vecs[4] = '{"x3",      2, TWO, THREE, TWO, THREE, 0, 0, 0,  R150, 28, 56};
        vecs[5] = '{"restart", 1, ONE, TWO, ONE,  TWO,   0, 0,  10, R50,  28, 28};

        // Reset state
        tick(); tick();
        check("rst outs", {27'd0, in_ready, out_valid, done, busy, pe_clear}, 32'd1);
        check("rst out_data", out_data, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            runJob(vecs[i]);
            tick();
        end

        // Reset partway through a window
        start = 1'b1; num_windows = 16'd1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = ONE; in_b = TWO;
        beats = 0;
        for (int c = 0; c < 40 && beats < 12; c++) begin
            #1;
            if (in_valid && in_ready) beats++;
            tick();
            start = 1'b0;
        end
        check("pre-reset beats", 32'(beats), 32'd12);
        reset = 1'b1;
        #1;
        check("midrst outs", {27'd0, in_ready, out_valid, done, busy, pe_clear}, 32'd1);
        check("midrst out_data", out_data, 32'h0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("post-rst busy", {31'd0, busy}, 32'd0);
        check("post-rst pe cleared", pe_result, 32'h0);
        sawIo = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            sawIo |= out_valid | in_ready | busy;
        end
        check("post-rst quiet", {31'd0, sawIo}, 32'd0);
        runJob(vecs[0]);
        tick();

        // Zero-window job
        start = 1'b1; num_windows = 16'd0;
        #1;
        check("zero done c0", {31'd0, done}, 32'd0);
        tick();
        start = 1'b0;
        #1;
        check("zero done c1", {30'd0, done, busy}, 32'd2);
        sawIo = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            sawIo |= out_valid | in_ready | done;
        end
        check("zero quiet", {31'd0, sawIo}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
